fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage that feeds the decode/control stage of the RV32I core. It owns the program counter and requests instructions from instruction memory over a req/ack handshake. It holds each fetched word stable until the downstream stage retires it, then computes the next PC: sequential (+4), or branch target when the control unit's resolved `Branch & zero` is asserted. It also presents the packed 11-bit control field {instr[30], instr[14:12], instr[6:0]} expected by the control unit.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `ADDR_W`, 32, PC / memory address width.
- `clk`  in  1  single core clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_req`  out  1  fetch request; held until acknowledged.
- `imem_addr`  out  ADDR_W  fetch address; stable while `imem_req`=1.
- `imem_ack`  in  1  memory accepts request; `imem_rdata` valid in same cycle.
- `imem_rdata`  in  32  instruction word.
- `stall`  in  1  downstream cannot retire current instruction.
- `branch_taken`  in  1  resolved Branch & zero for the held instruction.
- `branch_offset`  in  32  signed byte offset relative to `pc`.
- `instr`  out  32  held instruction.
- `ctrl_bits`  out  11  {instr[30], instr[14:12], instr[6:0]}, combinational from `instr`.
- `pc`  out  ADDR_W  address of `instr`.
- `instr_valid`  out  1  `instr`/`pc` valid for downstream.
- `misaligned`  out  1  misaligned-target trap flag; tied 0 when the check is compiled out.

## Operation
- States: IDLE, FETCH, HOLD, TRAP (TRAP exists only when the check is compiled in).
- Reset values:
  - state=IDLE, `pc`=RESET_PC, `instr`=32'h0000_0013 (NOP), `ctrl_bits`=11'h013.
  - `instr_valid`=0, `imem_req`=0, `imem_addr`=RESET_PC, `misaligned`=0.
- IDLE: exactly one cycle after reset release, then FETCH.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. On an edge with `imem_ack`=1: capture `imem_rdata` into `instr`, go HOLD.
- HOLD: `imem_req`=0, `instr_valid`=1. Edge with `stall`=0 retires the instruction:
  - next = `branch_taken` ? `pc`+`branch_offset` : `pc`+4.
  - Load next into `pc`, go FETCH.
- Edge with `stall`=1: no change. `branch_taken`/`branch_offset` are sampled only on the retire edge.
- Arithmetic: all PC sums are modulo 2^ADDR_W. 32'hFFFF_FFFC+4 → 32'h0000_0000. Negative offsets are two's complement.
- `imem_ack` outside FETCH is ignored. `imem_rdata` is ignored unless `imem_ack`=1 in FETCH.
- Reset mid-operation: `rst_n` low immediately forces all reset values, including `imem_req`=0, aborting any outstanding fetch.

## Timing
- Minimum 2 cycles per instruction: FETCH (acked same cycle) + HOLD (no stall).
- Fetch latency = cycles until `imem_ack`. `instr_valid` rises the cycle after the ack edge.
- `instr_valid` falls on the cycle after the retire edge. `imem_req` for the next PC rises in that same cycle.
- `ctrl_bits` follows `instr` with zero cycles of latency.
- First request appears 2 cycles after the `rst_n` rising edge.

## Configuration
- Macro: `FETCH_MISALIGN_CHK_EN`.
- Defined:
  - On retire, if next[1:0] != 2'b00, go TRAP.
  - TRAP holds `misaligned`=1, `instr_valid`=0, `imem_req`=0, and `pc`=the misaligned target.
  - TRAP is left only by reset.
- Undefined:
  - next[1:0] is forced to 2'b00 and fetch continues.
  - `misaligned` is constant 0.

## Test plan
- Reset release with memory acking every cycle, `stall`=0, RESET_PC=0 → `imem_addr` 0x0, 0x4, 0x8 on cycles 2, 4, 6; `instr_valid` pulses one cycle per instruction; `ctrl_bits`=11'h013 while in reset.
- Fetch of 0x40B50533 (bit30=1, funct3=000, opcode 0110011) → `ctrl_bits`=11'h433. Memory ack delayed 3 cycles → `imem_req`/`imem_addr` stable for all 3 cycles, `instr_valid` rises the cycle after the ack.
- `pc`=0x100, `stall` held 4 cycles with `branch_taken` toggling → outputs frozen. Retire with `branch_taken`=1, `branch_offset`=-8 → next `imem_addr`=0xF8.
- `pc`=0xFFFF_FFFC, retire with no branch → next `imem_addr`=0x0000_0000.
- Branch to offset +6 from 0x20:
  - with `FETCH_MISALIGN_CHK_EN` → `misaligned`=1, `pc`=0x26, no further `imem_req` until reset.
  - without it → fetch at 0x24.
- `rst_n` asserted while `imem_req`=1 and before the ack → `imem_req` drops asynchronously. After release, the first fetch is at RESET_PC; a late `imem_ack` is ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I instruction fetch stage: PC, imem req/ack handshake, hold-until-retire
// Optional macro FETCH_MISALIGN_CHK_EN: trap on misaligned next-PC instead of forcing alignment.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_offset,
  output logic [31:0]       instr,
  output logic [10:0]       ctrl_bits,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_valid,
  output logic              misaligned
);

`ifdef FETCH_MISALIGN_CHK_EN
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, TRAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
`endif

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] target_raw;
  logic [ADDR_W-1:0] target;

  // Offset is sign-extended to the PC width; sums wrap modulo 2^ADDR_W.
  assign target_raw = pc + (branch_taken ? ADDR_W'($signed(branch_offset)) : ADDR_W'(4));

`ifdef FETCH_MISALIGN_CHK_EN
  assign target     = target_raw;
  assign misaligned = (state == TRAP);
`else
  assign target     = target_raw & ~ADDR_W'(3);
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: if (imem_ack) state_nxt = HOLD;
      HOLD: begin
        if (!stall) begin
`ifdef FETCH_MISALIGN_CHK_EN
          state_nxt = (target[1:0] != 2'b00) ? TRAP : FETCH;
`else
          state_nxt = FETCH;
`endif
        end
      end
`ifdef FETCH_MISALIGN_CHK_EN
      TRAP:  state_nxt = TRAP;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      instr <= 32'h0000_0013;
    end else if (state == FETCH && imem_ack) begin
      instr <= imem_rdata;
    end else if (state == HOLD && !stall) begin
      pc <= target;
    end
  end

  // Outputs decode directly from the state register so reset drops imem_req immediately.
  assign imem_req    = (state == FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == HOLD);
  assign ctrl_bits   = {instr[30], instr[14:12], instr[6:0]};

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0000_0013;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_offset = 32'h0;
  logic [31:0] instr;
  logic [10:0] ctrl_bits;
  logic [31:0] pc;
  logic        instr_valid;
  logic        misaligned;

  int tests = 0;
  int fails = 0;

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .instr(instr), .ctrl_bits(ctrl_bits), .pc(pc),
    .instr_valid(instr_valid), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // Reset state, with a stray ack driven that must be ignored
    imem_ack = 1'b1;
    step(); step();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h13);
    chk("rst_ctrl", ctrl_bits, 11'h013);
    chk("rst_valid", instr_valid, 0);
    chk("rst_mis", misaligned, 0);

    // Cycle 1 after release is IDLE; fetches at 0,4,8 on cycles 2,4,6
    release_reset();
    chk("c1_idle_req", imem_req, 0);
    step(); chk("c2_req", imem_req, 1); chk("c2_addr", imem_addr, 32'h0);
    step(); chk("c3_valid", instr_valid, 1); chk("c3_req", imem_req, 0); chk("c3_pc", pc, 32'h0);
    step(); chk("c4_req", imem_req, 1); chk("c4_addr", imem_addr, 32'h4); chk("c4_valid", instr_valid, 0);
    step(); chk("c5_valid", instr_valid, 1);
    step(); chk("c6_addr", imem_addr, 32'h8); chk("c6_req", imem_req, 1);

    // Delayed ack: request held stable for 3 cycles
    imem_ack = 1'b0; imem_rdata = 32'h40B5_0533;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_req", imem_req, 1);
      chk("wait_addr", imem_addr, 32'h8);
      chk("wait_valid", instr_valid, 0);
    end
    imem_ack = 1'b1; stall = 1'b1;
    step(); imem_ack = 1'b0;
    chk("ack_valid", instr_valid, 1);
    chk("ack_instr", instr, 32'h40B5_0533);
    chk("ack_ctrl", ctrl_bits, 11'h433);
    chk("ack_pc", pc, 32'h8);

    // Branch from 0x8 by +0xF8 to reach pc 0x100
    stall = 1'b0; branch_taken = 1'b1; branch_offset = 32'hF8;
    step(); chk("br100_addr", imem_addr, 32'h100); chk("br100_valid", instr_valid, 0);
    branch_taken = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    step(); imem_ack = 1'b0; stall = 1'b1; branch_offset = 32'hFFFF_FFF8;
    chk("h100_pc", pc, 32'h100);
    for (int i = 0; i < 4; i++) begin
      branch_taken = ~branch_taken;
      step();
      chk("stall_valid", instr_valid, 1);
      chk("stall_pc", pc, 32'h100);
      chk("stall_req", imem_req, 0);
    end
    stall = 1'b0; branch_taken = 1'b1; branch_offset = 32'hFFFF_FFF8;
    step(); chk("neg_addr", imem_addr, 32'hF8); chk("neg_req", imem_req, 1);

    // Reach 0xFFFF_FFFC then wrap sequentially to 0
    imem_ack = 1'b1; branch_offset = 32'hFFFF_FF04; stall = 1'b1;
    step(); stall = 1'b0;
    step(); chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    branch_taken = 1'b0;
    step(); chk("top_pc", pc, 32'hFFFF_FFFC);
    step(); chk("wrap_addr", imem_addr, 32'h0); chk("wrap_req", imem_req, 1);

    // 0x0 -> 0x20, then branch +6
    step(); branch_taken = 1'b1; branch_offset = 32'h20;
    step(); chk("a20_addr", imem_addr, 32'h20);
    branch_offset = 32'h6;
    step(); chk("a20_pc", pc, 32'h20);
    step();
`ifdef FETCH_MISALIGN_CHK_EN
    chk("trap_mis", misaligned, 1);
    chk("trap_pc", pc, 32'h26);
    chk("trap_req", imem_req, 0);
    chk("trap_valid", instr_valid, 0);
    step(); step();
    chk("trap_stay_req", imem_req, 0);
    chk("trap_stay_mis", misaligned, 1);
`else
    chk("align_addr", imem_addr, 32'h24);
    chk("align_req", imem_req, 1);
    chk("align_mis", misaligned, 0);
`endif

    // Reset mid-fetch: request drops asynchronously, restart at RESET_PC
    branch_taken = 1'b0; imem_ack = 1'b0; rst_n = 1'b0;
    step();
    release_reset();
    step(); imem_ack = 1'b1;
    step(); step(); imem_ack = 1'b0;
    chk("pre_abort_addr", imem_addr, 32'h4);
    step(); chk("pre_abort_req", imem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", imem_req, 0);
    chk("async_pc", pc, 32'h0);
    chk("async_valid", instr_valid, 0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    release_reset();
    chk("late_ack_instr", instr, 32'h13);
    chk("late_ack_valid", instr_valid, 0);
    step(); chk("restart_addr", imem_addr, 32'h0); chk("restart_req", imem_req, 1);
    step(); chk("restart_instr", instr, 32'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
